ibex_mem_responder: RTL and testbench

Responder end of the Ibex instruction/data memory interface (req/gnt/rvalid protocol). It models a single-port, word-organised SRAM slave with fixed response latency, bounded outstanding requests, grant throttling and out-of-range error responses. It sits on the simulation/FPGA top level opposite the core's `data_*` or `instr_*` ports, and is the bench-side counterpart the core and tracer are exercised against.

---
 rtl/ibex_mem_responder_pkg.sv | 13 +
 rtl/ibex_mem_responder_if.sv | 25 ++
 rtl/ibex_mem_responder_ram.sv | 34 +++
 rtl/ibex_mem_responder.sv | 124 ++++++++++++
 tb/tb_ibex_mem_responder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_mem_responder_pkg.sv
// Shared types for the Ibex memory responder: response pipeline entry and bus geometry.
package ibex_mem_responder_pkg;

    localparam int unsigned BusWidth  = 32;
    localparam int unsigned LaneCount = BusWidth / 8;

    typedef struct packed {
        logic                valid;
        logic                err;
        logic [BusWidth-1:0] rdata;
    } mem_resp_t;

endpackage

// File: rtl/ibex_mem_responder_if.sv
// req/gnt/rvalid memory bus between an Ibex-style requester and the responder.
interface ibex_mem_responder_if;
    import ibex_mem_responder_pkg::*;

    logic                 req_i;
    logic                 gnt_o;
    logic                 we_i;
    logic [LaneCount-1:0] be_i;
    logic [BusWidth-1:0]  addr_i;
    logic [BusWidth-1:0]  wdata_i;
    logic                 stall_i;
    logic                 rvalid_o;
    logic [BusWidth-1:0]  rdata_o;
    logic                 err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, stall_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, stall_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/ibex_mem_responder_ram.sv
// Single-port word RAM with byte-lane write enables and registered read data.
module ibex_mem_responder_ram
    import ibex_mem_responder_pkg::*;
#(
    parameter int unsigned MemWords = 1024,
    localparam int unsigned IdxW    = $clog2(MemWords)
) (
    input  logic                 clk_i,
    input  logic                 en,
    input  logic                 we,
    input  logic [LaneCount-1:0] be,
    input  logic [IdxW-1:0]      idx,
    input  logic [BusWidth-1:0]  wdata,
    output logic [BusWidth-1:0]  rdata
);

    logic [BusWidth-1:0] mem [MemWords];

    // Read data only updates on a read access so it stays stable until the next read.
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                for (int n = 0; n < int'(LaneCount); n++) begin
                    if (be[n]) begin
                        mem[idx][8*n +: 8] <= wdata[8*n +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/ibex_mem_responder.sv
// Responder end of the Ibex req/gnt/rvalid memory interface: grant throttling,
// range checking, outstanding-request cap and fixed-latency in-order responses.
module ibex_mem_responder
    import ibex_mem_responder_pkg::*;
#(
    parameter int unsigned   MemWords       = 1024,
    parameter logic [31:0]   AddrBase       = 32'h0000_0000,
    parameter int unsigned   RespLatency    = 1,
    parameter int unsigned   MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ibex_mem_responder_if.slave  bus
);

    localparam int unsigned IdxW    = $clog2(MemWords);
    localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
    localparam logic [32:0] SpanLo  = {1'b0, AddrBase};
    localparam logic [32:0] SpanHi  = SpanLo + 33'(4 * MemWords);

    if (MemWords < 4 || (MemWords & (MemWords - 1)) != 0) begin : g_bad_words
        $error("MemWords must be a power of two and at least 4");
    end
    if (RespLatency < 1 || RespLatency > 8) begin : g_bad_latency
        $error("RespLatency must be in 1..8");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > RespLatency + 1) begin : g_bad_outstanding
        $error("MaxOutstanding must be in 1..RespLatency+1");
    end
    if (AddrBase[IdxW+1:0] != '0) begin : g_bad_base
        $error("AddrBase must be aligned to 4*MemWords");
    end

    logic [CntW-1:0]     count;
    logic                gnt;
    logic                in_range;
    logic [32:0]         addr_ext;
    logic [31:0]         offs;
    logic [IdxW-1:0]     idx;
    logic [BusWidth-1:0] ram_rdata;
    mem_resp_t           resp_p0;
    mem_resp_t           resp_out;
    logic                vld_p0;
    logic                err_p0;
    logic                rd_p0;

    // Unsigned 33-bit compare so a range ending at 2^32 cannot wrap.
    assign addr_ext = {1'b0, bus.addr_i};
    assign in_range = (addr_ext >= SpanLo) && (addr_ext < SpanHi);
    assign offs     = bus.addr_i - AddrBase;
    assign idx      = IdxW'(offs >> 2);

    // A response leaving this cycle frees a slot for a same-cycle grant.
    assign gnt       = bus.req_i & ~bus.stall_i &
                       ((count < CntW'(MaxOutstanding)) | resp_out.valid);
    assign bus.gnt_o = gnt;

    ibex_mem_responder_ram #(
        .MemWords (MemWords)
    ) u_ram (
        .clk_i (clk_i),
        .en    (gnt & in_range),
        .we    (bus.we_i),
        .be    (bus.be_i),
        .idx   (idx),
        .wdata (bus.wdata_i),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count <= '0;
        end else begin
            case ({gnt, resp_out.valid})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stage p0: grant captured alongside the synchronous RAM read.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_p0 <= 1'b0;
            err_p0 <= 1'b0;
            rd_p0  <= 1'b0;
        end else begin
            vld_p0 <= gnt;
            err_p0 <= ~in_range;
            rd_p0  <= ~bus.we_i & in_range;
        end
    end

    assign resp_p0.valid = vld_p0;
    assign resp_p0.err   = err_p0;
    assign resp_p0.rdata = rd_p0 ? ram_rdata : '0;

    // Stages p1..: plain delay line; only the valid bits are cleared by reset.
    if (RespLatency == 1) begin : g_lat1
        assign resp_out = resp_p0;
    end else begin : g_latn
        mem_resp_t pipe_p [RespLatency-1];

        always_ff @(posedge clk_i) begin
            pipe_p[0] <= resp_p0;
            for (int i = 1; i < int'(RespLatency) - 1; i++) begin
                pipe_p[i] <= pipe_p[i-1];
            end
            if (!rst_ni) begin
                for (int i = 0; i < int'(RespLatency) - 1; i++) begin
                    pipe_p[i].valid <= 1'b0;
                end
            end
        end

        assign resp_out = pipe_p[RespLatency-2];
    end

    assign bus.rvalid_o = resp_out.valid;
    assign bus.err_o    = resp_out.valid & resp_out.err;
    assign bus.rdata_o  = resp_out.valid ? resp_out.rdata : '0;

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Scoreboard bench for ibex_mem_responder: driver pushes expected responses, monitor checks them.
module tb_ibex_mem_responder;

    localparam int Lat = 3;
    localparam int MaxOut = 2;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst_ni;
    int   cyc;
    int   total;
    int   bad;
    exp_t exp_q [$];

    ibex_mem_responder_if bus ();

    ibex_mem_responder #(
        .MemWords       (1024),
        .AddrBase       (32'h0000_0000),
        .RespLatency    (Lat),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per response and checks data, error and arrival cycle.
    always @(negedge clk) begin
        if (cyc >= 2) begin
            if (bus.rvalid_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rvalid: got rdata %h err %0d with nothing pending (cycle %0d)",
                             bus.rdata_o, bus.err_o, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_cycle", 32'(cyc), 32'(e.due));
                    check("resp_rdata", bus.rdata_o, e.rdata);
                    check("resp_err", {31'b0, bus.err_o}, {31'b0, e.err});
                end
            end else begin
                check("idle_outputs", {bus.err_o, bus.rdata_o[30:0]}, 32'h0);
                if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing_rvalid: got none expected response due cycle %0d (cycle %0d)", e.due, cyc);
                end
            end
        end
    end

    task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_rd, output int gc);
        bus.req_i   = 1'b1;
        bus.we_i    = w;
        bus.addr_i  = a;
        bus.be_i    = b;
        bus.wdata_i = d;
        gc = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.gnt_o) begin
                gc = cyc;
                exp_q.push_back('{due: cyc + Lat, err: e_err, rdata: e_rd});
                break;
            end
        end
        if (gc < 0) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: got no gnt expected gnt for addr %h", a);
        end
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc;
        int g [6];
        int rel;
        total = 0;
        bad   = 0;
        rst_ni = 1'b0;
        bus.req_i = 1'b0;
        bus.we_i = 1'b0;
        bus.be_i = 4'h0;
        bus.addr_i = 32'h0;
        bus.wdata_i = 32'h0;
        bus.stall_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
        check("rst_rdata", bus.rdata_o, 32'h0);
        check("rst_err", {31'b0, bus.err_o}, 32'h0);
        check("rst_gnt_idle", {31'b0, bus.gnt_o}, 32'h0);
        @(posedge clk); #1;
        bus.req_i = 1'b1;
        @(negedge clk);
        check("rst_gnt_req", {31'b0, bus.gnt_o}, 32'h1);
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Full write then read
        do_req(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, gc);
        do_req(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, gc);

        // Partial write over all-ones; read ignores byte enables
        do_req(1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, gc);
        do_req(1'b1, 32'h20, 4'b0101, 32'h1122_3344, 1'b0, 32'h0, gc);
        do_req(1'b1, 32'h20, 4'b0000, 32'h0000_0000, 1'b0, 32'h0, gc);
        do_req(1'b0, 32'h20, 4'b0001, 32'h0, 1'b0, 32'hFF22_FF44, gc);

        // Range edges: last word, word 0, and out-of-range accesses leave memory alone
        do_req(1'b1, 32'hFFC, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0, gc);
        do_req(1'b1, 32'h000, 4'hF, 32'h0123_4567, 1'b0, 32'h0, gc);
        do_req(1'b1, 32'h1000, 4'hF, 32'h55AA_55AA, 1'b1, 32'h0, gc);
        do_req(1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, 32'h0, gc);
        do_req(1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, 1'b1, 32'h0, gc);
        do_req(1'b0, 32'hFFE, 4'hF, 32'h0, 1'b0, 32'hCAFE_F00D, gc);
        do_req(1'b0, 32'h000, 4'hF, 32'h0, 1'b0, 32'h0123_4567, gc);
        drain();

        // Six back-to-back requests against a cap of two with latency three
        do_req(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, g[0]);
        do_req(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'hFF22_FF44, g[1]);
        do_req(1'b0, 32'hFFC, 4'hF, 32'h0, 1'b0, 32'hCAFE_F00D, g[2]);
        do_req(1'b0, 32'h000, 4'hF, 32'h0, 1'b0, 32'h0123_4567, g[3]);
        do_req(1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, 32'h0, g[4]);
        do_req(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, g[5]);
        check("cap_gap1", 32'(g[1] - g[0]), 32'd1);
        check("cap_gap2", 32'(g[2] - g[0]), 32'd3);
        check("cap_gap3", 32'(g[3] - g[0]), 32'd4);
        check("cap_gap4", 32'(g[4] - g[0]), 32'd6);
        check("cap_gap5", 32'(g[5] - g[0]), 32'd7);
        drain();

        // Stall holds off the grant; release grants in the same cycle
        bus.req_i = 1'b1;
        bus.we_i = 1'b0;
        bus.addr_i = 32'h20;
        bus.be_i = 4'hF;
        bus.stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_gnt", {31'b0, bus.gnt_o}, 32'h0);
        end
        @(posedge clk); #1;
        bus.stall_i = 1'b0;
        rel = cyc;
        do_req(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'hFF22_FF44, gc);
        check("stall_release", 32'(gc), 32'(rel));
        drain();

        // Reset with two reads in flight drops both responses
        do_req(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, g[0]);
        do_req(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'hFF22_FF44, g[1]);
        rst_ni = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        check("post_rst_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
        check("post_rst_rdata", bus.rdata_o, 32'h0);
        check("post_rst_count", 32'(dut.count), 32'h0);
        @(posedge clk); #1;
        rel = cyc;
        do_req(1'b0, 32'hFFC, 4'hF, 32'h0, 1'b0, 32'hCAFE_F00D, gc);
        check("post_rst_grant", 32'(gc), 32'(rel));
        do_req(1'b0, 32'h000, 4'hF, 32'h0, 1'b0, 32'h0123_4567, gc);
        check("post_rst_grant2", 32'(gc), 32'(rel + 1));
        drain();
        repeat (4) @(posedge clk);
        #1;

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
